// File: rtl/exp_dt_sched.sv
// rtl/exp_dt_sched.sv - per-channel elapsed-time scheduler feeding the fixed-tau exp LUT unit
// Optional: EXP_DT_NOVLD_BYPASS_EN skips the exp request for never-evented channels.
module exp_dt_sched #(
  parameter int N_CH    = 16,
  parameter int wTS     = 16,
  parameter int wTOT    = 12,
  parameter int wMAX    = 8,
  parameter int EXP_LAT = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    ev_valid,
  input  logic [$clog2(N_CH)-1:0] ev_ch,
  input  logic                    q_valid,
  output logic                    q_ready,
  input  logic [$clog2(N_CH)-1:0] q_ch,
  input  logic                    exp_busy,
  output logic                    idle,
  output logic                    exp_req,
  output logic [wTOT-1:0]         exp_tn,
  input  logic [wMAX-1:0]         exp_result,
  output logic                    r_valid,
  output logic [$clog2(N_CH)-1:0] r_ch,
  output logic [wMAX-1:0]         r_val,
  output logic                    r_sat
);

  localparam int CW    = $clog2(N_CH);
  localparam int DEPTH = EXP_LAT + 2;

  logic [wTS-1:0]   now;
  logic [wTS-1:0]   ts [N_CH];
  logic [N_CH-1:0]  vld;

  logic [DEPTH-1:0] p_valid;
  logic [CW-1:0]    p_ch [DEPTH];
  logic [DEPTH-1:1] p_sat;
`ifdef EXP_DT_NOVLD_BYPASS_EN
  logic [DEPTH-1:1] p_byp;
`endif
  logic [wTS-1:0]   s0_ts;
  logic             s0_vld;
  logic [wTS-1:0]   dt;
  logic             dt_sat;
  logic             accept;

  assign q_ready = ~exp_busy & ~reset;
  assign accept  = q_valid & q_ready;
  assign idle    = ~|p_valid;
  assign dt      = now - s0_ts;
  assign dt_sat  = ~s0_vld | (|dt[wTS-1:wTOT]);

  // Nonblocking write keeps a same-edge query reading the old timestamp.
  always_ff @(posedge clk) begin
    if (reset) begin
      now <= '0;
      vld <= '0;
    end else begin
      if (tick)
        now <= now + 1'b1;
      if (ev_valid) begin
        ts[ev_ch]  <= now;
        vld[ev_ch] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p_ch[0] <= q_ch;
      s0_ts   <= ts[q_ch];
      s0_vld  <= vld[q_ch];
    end
    for (int i = 1; i < DEPTH; i++)
      p_ch[i] <= p_ch[i-1];
    p_sat[1] <= dt_sat;
    for (int i = 2; i < DEPTH; i++)
      p_sat[i] <= p_sat[i-1];
`ifdef EXP_DT_NOVLD_BYPASS_EN
    p_byp[1] <= ~s0_vld;
    for (int i = 2; i < DEPTH; i++)
      p_byp[i] <= p_byp[i-1];
`endif
  end

  // Only the valid bits and outputs are reset, so in-flight queries vanish.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= '0;
      exp_req <= 1'b0;
      exp_tn  <= '0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_val   <= '0;
      r_sat   <= 1'b0;
    end else begin
      p_valid <= {p_valid[DEPTH-2:0], accept};
`ifdef EXP_DT_NOVLD_BYPASS_EN
      exp_req <= p_valid[0] & s0_vld;
`else
      exp_req <= p_valid[0];
`endif
      if (p_valid[0])
        exp_tn <= dt_sat ? {wTOT{1'b1}} : dt[wTOT-1:0];
      r_valid <= p_valid[DEPTH-1];
      if (p_valid[DEPTH-1]) begin
        r_ch  <= p_ch[DEPTH-1];
        r_sat <= p_sat[DEPTH-1];
`ifdef EXP_DT_NOVLD_BYPASS_EN
        r_val <= p_byp[DEPTH-1] ? '0 : exp_result;
`else
        r_val <= exp_result;
`endif
      end
    end
  end

endmodule

// File: tb/tb_exp_dt_sched.sv
// tb/tb_exp_dt_sched.sv - randomized and directed bench for exp_dt_sched with an edge-indexed reference model
module tb_exp_dt_sched;
  localparam int EXP_LAT = 5;
  localparam int DEPTH   = EXP_LAT + 2;

  logic clk = 0, reset = 1, tick = 0, ev_valid = 0, q_valid = 0, exp_busy = 0;
  logic [3:0] ev_ch = 0, q_ch = 0;
  logic q_ready, idle, exp_req, r_valid, r_sat;
  logic [11:0] exp_tn;
  logic [7:0] exp_result = 0, r_val;
  logic [3:0] r_ch;

  always #5 clk = ~clk;

  exp_dt_sched #(.N_CH(16), .wTS(16), .wTOT(12), .wMAX(8), .EXP_LAT(EXP_LAT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .ev_valid(ev_valid), .ev_ch(ev_ch),
    .q_valid(q_valid), .q_ready(q_ready), .q_ch(q_ch), .exp_busy(exp_busy), .idle(idle),
    .exp_req(exp_req), .exp_tn(exp_tn), .exp_result(exp_result),
    .r_valid(r_valid), .r_ch(r_ch), .r_val(r_val), .r_sat(r_sat)
  );

  int edge_n = 0;
  int last_acc = -100;
  int n_pass = 0, n_total = 0;
  logic [15:0] now_m;
  logic [15:0] ts_m [16];
  bit          vld_m [16];
  logic [11:0] req_tn_m [int];
  logic [3:0]  r_ch_m [int];
  bit          r_sat_m [int];
  logic [7:0]  r_val_m [int];
  logic [7:0]  sched [int];
  logic [11:0] tn_log [$];
  logic [3:0]  rch_log [$];
  bit          rsat_log [$];
  logic [7:0]  rval_log [$];
  int          redge_log [$];

  function automatic logic [7:0] exp_f(input logic [11:0] tn);
    return 8'((32'(tn) * 7 + 13) ^ (32'(tn) >> 4));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
  endtask

  // Reference model: outputs expected at each edge, keyed by edge number.
  always @(posedge clk) begin : model
    logic [15:0] dt;
    logic [11:0] tn;
    bit sat, issue;
    edge_n++;
    if (reset) begin
      now_m = 0;
      foreach (vld_m[i]) vld_m[i] = 0;
      for (int k = edge_n; k <= edge_n + DEPTH; k++) begin
        req_tn_m.delete(k); r_ch_m.delete(k); r_sat_m.delete(k); r_val_m.delete(k);
      end
      last_acc = -100;
    end else begin
      if (q_valid && !exp_busy) begin
        dt = now_m + {15'd0, tick} - ts_m[q_ch];
        sat = !vld_m[q_ch] || dt > 16'd4095;
        tn = sat ? 12'hfff : dt[11:0];
`ifdef EXP_DT_NOVLD_BYPASS_EN
        issue = vld_m[q_ch];
`else
        issue = 1;
`endif
        if (issue) req_tn_m[edge_n + 1] = tn;
        r_ch_m[edge_n + DEPTH]  = q_ch;
        r_sat_m[edge_n + DEPTH] = sat;
        r_val_m[edge_n + DEPTH] = issue ? exp_f(tn) : 8'd0;
        last_acc = edge_n;
      end
      if (ev_valid) begin
        ts_m[ev_ch] = now_m;
        vld_m[ev_ch] = 1;
      end
      if (tick) now_m = now_m + 16'd1;
    end
  end

  // Exp unit emulation: samples exp_req one edge after it rises, answers EXP_LAT edges later.
  always @(negedge clk) begin
    if (exp_req) sched[edge_n + 1 + EXP_LAT] = exp_f(exp_tn);
    exp_result = sched.exists(edge_n + 1) ? sched[edge_n + 1] : 8'($urandom);
  end

  always @(negedge clk) begin
    if (edge_n >= 1) begin
      chk("q_ready", q_ready, !exp_busy && !reset);
      chk("exp_req", exp_req, req_tn_m.exists(edge_n));
      if (req_tn_m.exists(edge_n)) chk("exp_tn", exp_tn, req_tn_m[edge_n]);
      chk("r_valid", r_valid, r_ch_m.exists(edge_n));
      if (r_ch_m.exists(edge_n)) begin
        chk("r_ch", r_ch, r_ch_m[edge_n]);
        chk("r_val", r_val, r_val_m[edge_n]);
        chk("r_sat", r_sat, r_sat_m[edge_n]);
      end
      chk("idle", idle, (edge_n - last_acc) > 6);
      if (exp_req) tn_log.push_back(exp_tn);
      if (r_valid) begin
        rch_log.push_back(r_ch); rsat_log.push_back(r_sat);
        rval_log.push_back(r_val); redge_log.push_back(edge_n);
      end
    end
  end

  task automatic step(input bit t, input bit ev, input int evc, input bit q, input int qc, input bit busy);
    tick = t; ev_valid = ev; ev_ch = 4'(evc); q_valid = q; q_ch = 4'(qc); exp_busy = busy;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    idle_n(n);
    reset = 0;
  endtask

  task automatic clear_logs();
    tn_log.delete(); rch_log.delete(); rsat_log.delete(); rval_log.delete(); redge_log.delete();
  endtask

  initial begin
    int acc;
    do_reset(2);
    chk("reset_idle", idle, 1);
    chk("reset_r_valid", r_valid, 0);

    // ev ch2 at now=3, ten ticks later query -> dt=10
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
    clear_logs();
    step(0, 0, 0, 1, 2, 0);
    acc = last_acc;
    idle_n(9);
    chk("t1_nreq", tn_log.size(), 1);
    chk("t1_tn", (tn_log.size() > 0) ? 32'(tn_log[0]) : 32'hffffffff, 10);
    chk("t1_rch", (rch_log.size() > 0) ? 32'(rch_log[0]) : 32'hffffffff, 2);
    chk("t1_rsat", (rsat_log.size() > 0) ? 32'(rsat_log[0]) : 32'hffffffff, 0);
    chk("t1_lat", (redge_log.size() > 0) ? 32'(redge_log[0] - acc) : 32'hffffffff, 7);

    // long gap saturates
    step(0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 5000; i++) step(1, 0, 0, 0, 0, 0);
    clear_logs();
    step(0, 0, 0, 1, 5, 0);
    idle_n(9);
    chk("t2_tn", (tn_log.size() > 0) ? 32'(tn_log[0]) : 32'hffffffff, 4095);
    chk("t2_rsat", (rsat_log.size() > 0) ? 32'(rsat_log[0]) : 32'hffffffff, 1);

    // back-to-back queries keep order
    clear_logs();
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, i, 0);
    idle_n(9);
    chk("t3_count", rch_log.size(), 16);
    for (int i = 0; i < 16; i++)
      chk("t3_order", (rch_log.size() > i) ? 32'(rch_log[i]) : 32'hffffffff, i);
    chk("t3_contig", (redge_log.size() == 16) ? 32'(redge_log[15] - redge_log[0]) : 32'hffffffff, 15);

    // same-edge event and query: query sees the old timestamp
    do_reset(1);
    step(0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);
    clear_logs();
    step(0, 1, 3, 1, 3, 0);
    step(0, 0, 0, 1, 3, 0);
    idle_n(9);
    chk("t4_tn_old", (tn_log.size() > 0) ? 32'(tn_log[0]) : 32'hffffffff, 20);
    chk("t4_tn_new", (tn_log.size() > 1) ? 32'(tn_log[1]) : 32'hffffffff, 0);

    // busy blocks queries; reset drops in-flight work
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 1, 1);
      chk("t5_qready", q_ready, 0);
    end
    idle_n(3);
    chk("t5_noreq", tn_log.size(), 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 1, 5, 0);
    step(0, 0, 0, 1, 3, 0);
    clear_logs();
    do_reset(1);
    idle_n(10);
    chk("t5_nor", rch_log.size(), 0);
    chk("t5_idle", idle, 1);

    // never-evented channel
    clear_logs();
    step(0, 0, 0, 1, 7, 0);
    idle_n(9);
`ifdef EXP_DT_NOVLD_BYPASS_EN
    chk("t6_noreq", tn_log.size(), 0);
    chk("t6_rval", (rval_log.size() > 0) ? 32'(rval_log[0]) : 32'hffffffff, 0);
`else
    chk("t6_tn", (tn_log.size() > 0) ? 32'(tn_log[0]) : 32'hffffffff, 4095);
`endif
    chk("t6_rsat", (rsat_log.size() > 0) ? 32'(rsat_log[0]) : 32'hffffffff, 1);
    chk("t6_rch", (rch_log.size() > 0) ? 32'(rch_log[0]) : 32'hffffffff, 7);

    // randomized traffic against the model
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 99) < 30, $urandom_range(0, 15),
           $urandom_range(0, 99) < 60, $urandom_range(0, 15), $urandom_range(0, 99) < 8);
    end
    reset = 0;
    idle_n(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
